// File: rtl/apb_param_mem_slave.sv
// APB slave in front of a single-port memory with async read data.
// Supports programmable wait states, byte strobes, slverr reporting and abort on deselect.
module apb_param_mem_slave #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  enable,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_W-1:0]     wdata,
  input  logic [DATA_W/8-1:0]   strb,
  input  logic [WAIT_W-1:0]     wait_cycles,
  output logic                  ready,
  output logic [DATA_W-1:0]     rdata,
  output logic                  slverr,
  output logic                  mem_wren,
  output logic                  mem_rden,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_be,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  // One extra bit so a depth equal to 2^ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(MEM_DEPTH);

  state_t                state, state_d;
  logic [WAIT_W-1:0]     cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W/8-1:0]   strb_q;
  logic                  write_q;
  logic                  err_q;

  logic                  capture;
  logic                  setup_err;
  logic                  write_sel;
  logic                  err_sel;
  logic                  enter_done;

  assign setup_err = ({1'b0, addr} >= DEPTH_LIM) || (!write && (strb != '0));

  // Zero-wait transfers jump straight from IDLE to DONE, so use the live bus values.
  assign write_sel  = capture ? write     : write_q;
  assign err_sel    = capture ? setup_err : err_q;
  assign enter_done = (state_d == ST_DONE);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state;
    capture = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel && !enable) begin
          capture = 1'b1;
          state_d = (wait_cycles == '0) ? ST_DONE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!sel || !enable)            state_d = ST_IDLE;
        else if (cnt == WAIT_W'(1))     state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ready    <= 1'b0;
      slverr   <= 1'b0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
      rdata    <= '0;
    end else begin
      state <= state_d;
      if (capture)                cnt <= wait_cycles;
      else if (state == ST_WAIT)  cnt <= cnt - WAIT_W'(1);
      ready    <= enter_done;
      slverr   <= enter_done && err_sel;
      mem_wren <= enter_done && write_sel && !err_sel;
      mem_rden <= (state_d == ST_WAIT) && !write_sel;
      if (enter_done && !write_sel) rdata <= err_sel ? '0 : mem_rdata;
    end
  end

  // NOTE: transfer attributes are pure datapath, qualified by the FSM, so they carry no reset.
  always_ff @(posedge clk) begin
    if (capture) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      strb_q  <= strb;
      write_q <= write;
      err_q   <= setup_err;
    end
  end

  assign mem_addr  = (state == ST_IDLE) ? addr : addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = strb_q;

endmodule

// File: tb/tb_apb_param_mem_slave.sv
// Bench for apb_param_mem_slave: an 8-bit/256-word instance and a 32-bit/16-word
// instance share one APB bus, each backed by a behavioural memory and a reference copy.
module tb_apb_param_mem_slave;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    int          wr_n;
    int          rd_n;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel8, sel32, enable, write;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  strb;
  logic [7:0]  wait_cycles;

  logic        ready8, slverr8, mem_wren8, mem_rden8;
  logic [7:0]  rdata8, mem_addr8, mem_wdata8, mem_rdata8;
  logic [0:0]  mem_be8;

  logic        ready32, slverr32, mem_wren32, mem_rden32;
  logic [31:0] rdata32, mem_wdata32, mem_rdata32;
  logic [7:0]  mem_addr32;
  logic [3:0]  mem_be32;

  logic [7:0]  mem8  [256];
  logic [31:0] mem32 [256];
  logic [7:0]  ref8  [256];
  logic [31:0] ref32 [256];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  apb_param_mem_slave #(.ADDR_W(8), .DATA_W(8), .MEM_DEPTH(256), .WAIT_W(8)) u_dut8 (
    .clk(clk), .reset(reset), .sel(sel8), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata[7:0]), .strb(strb[0:0]), .wait_cycles(wait_cycles),
    .ready(ready8), .rdata(rdata8), .slverr(slverr8), .mem_wren(mem_wren8),
    .mem_rden(mem_rden8), .mem_addr(mem_addr8), .mem_wdata(mem_wdata8),
    .mem_be(mem_be8), .mem_rdata(mem_rdata8)
  );

  apb_param_mem_slave #(.ADDR_W(8), .DATA_W(32), .MEM_DEPTH(16), .WAIT_W(8)) u_dut32 (
    .clk(clk), .reset(reset), .sel(sel32), .enable(enable), .write(write),
    .addr(addr), .wdata(wdata), .strb(strb), .wait_cycles(wait_cycles),
    .ready(ready32), .rdata(rdata32), .slverr(slverr32), .mem_wren(mem_wren32),
    .mem_rden(mem_rden32), .mem_addr(mem_addr32), .mem_wdata(mem_wdata32),
    .mem_be(mem_be32), .mem_rdata(mem_rdata32)
  );

  // Behavioural memories: async read, byte-enabled synchronous write.
  assign mem_rdata8  = mem8[mem_addr8];
  assign mem_rdata32 = mem32[mem_addr32];

  always @(posedge clk) begin
    if (mem_wren8 && mem_be8[0]) mem8[mem_addr8] <= mem_wdata8;
  end

  always @(posedge clk) begin
    if (mem_wren32)
      for (int k = 0; k < 4; k++)
        if (mem_be32[k]) mem32[mem_addr32][8*k +: 8] <= mem_wdata32[8*k +: 8];
  end

  // Reference model: expected outcome of one complete transfer, from the protocol rules.
  function automatic obs_t predict(input bit tgt, input bit wr, input logic [7:0] a,
                                   input logic [3:0] s, input logic [7:0] n);
    obs_t e;
    int   depth = tgt ? 16 : 256;
    logic [3:0] s_eff = tgt ? s : {3'b000, s[0]};
    e.err  = (int'(a) >= depth) || (!wr && s_eff != 4'h0);
    e.lat  = int'(n) + 1;
    e.wr_n = (wr && !e.err) ? 1 : 0;
    e.rd_n = wr ? 0 : int'(n);
    e.rd   = (wr || e.err) ? 32'h0 : (tgt ? ref32[a] : {24'h0, ref8[a]});
    return e;
  endfunction

  task automatic clear_bus();
    sel8 = 1'b0; sel32 = 1'b0; enable = 1'b0; write = 1'b0;
    addr = '0; wdata = '0; strb = '0; wait_cycles = '0;
  endtask

  // Runs one transfer starting just after a rising edge; returns at the same phase,
  // one edge after ready, with the bus idle so a new setup can follow immediately.
  task automatic xfer(input bit tgt, input bit wr, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [7:0] n, output obs_t o);
    logic rdy, er, wren, rden;
    logic [31:0] rd;
    o = '{default: 0};
    if (tgt) sel32 = 1'b1; else sel8 = 1'b1;
    enable = 1'b0; write = wr; addr = a; wdata = d; strb = s; wait_cycles = n;
    @(posedge clk); #1;
    enable = 1'b1;
    wait_cycles = 8'($urandom);
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      rdy  = tgt ? ready32    : ready8;
      er   = tgt ? slverr32   : slverr8;
      wren = tgt ? mem_wren32 : mem_wren8;
      rden = tgt ? mem_rden32 : mem_rden8;
      rd   = tgt ? rdata32    : {24'h0, rdata8};
      if (wren) o.wr_n++;
      if (rden) o.rd_n++;
      if (rdy) begin
        o.lat = c; o.err = er; o.rd = rd;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    sel8 = 1'b0; sel32 = 1'b0; enable = 1'b0;
  endtask

  task automatic test_reset();
    clear_bus();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ready8, slverr8, mem_wren8, mem_rden8, rdata8} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset8 outputs got %h want 0", {ready8, slverr8, mem_wren8, mem_rden8, rdata8});
    end
    vectors++;
    if ({ready32, slverr32, mem_wren32, mem_rden32, rdata32} !== 36'h0) begin
      miscompares++;
      $display("FAIL reset32 outputs got %h want 0", {ready32, slverr32, mem_wren32, mem_rden32, rdata32});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    obs_t o;
    xfer(1'b0, 1'b1, 8'h10, 32'hA5, 4'h1, 8'd0, o);
    ref8[8'h10] = 8'hA5;
    vectors++; if (o.lat !== 1) begin miscompares++; $display("FAIL write lat got %0d want 1", o.lat); end
    vectors++; if (o.err !== 1'b0) begin miscompares++; $display("FAIL write slverr got %b want 0", o.err); end
    vectors++; if (o.wr_n !== 1) begin miscompares++; $display("FAIL write wren_cycles got %0d want 1", o.wr_n); end
    vectors++; if (mem8[8'h10] !== 8'hA5) begin miscompares++; $display("FAIL write mem got %h want a5", mem8[8'h10]); end
  endtask

  task automatic test_read();
    obs_t o;
    xfer(1'b0, 1'b0, 8'h10, 32'h0, 4'h0, 8'd3, o);
    vectors++; if (o.lat !== 4) begin miscompares++; $display("FAIL read lat got %0d want 4", o.lat); end
    vectors++; if (o.rd !== 32'hA5) begin miscompares++; $display("FAIL read rdata got %h want a5", o.rd); end
    vectors++; if (o.rd_n !== 3) begin miscompares++; $display("FAIL read rden_cycles got %0d want 3", o.rd_n); end
    vectors++; if (o.err !== 1'b0) begin miscompares++; $display("FAIL read slverr got %b want 0", o.err); end
  endtask

  task automatic test_idle_access();
    obs_t o;
    int   seen = 0;
    logic [7:0] keep = ref8[8'h50];
    sel8 = 1'b1; enable = 1'b1; write = 1'b1; addr = 8'h50;
    wdata = {24'h0, keep ^ 8'h3C}; strb = 4'h1; wait_cycles = 8'd0;
    repeat (4) begin
      @(negedge clk);
      if (ready8 || mem_wren8) seen++;
      @(posedge clk); #1;
    end
    clear_bus();
    @(posedge clk); #1;
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL idle_access activity got %0d want 0", seen); end
    vectors++; if (mem8[8'h50] !== keep) begin miscompares++; $display("FAIL idle_access mem got %h want %h", mem8[8'h50], keep); end
    xfer(1'b0, 1'b0, 8'h50, 32'h0, 4'h0, 8'd0, o);
    vectors++; if (o.rd !== {24'h0, keep}) begin miscompares++; $display("FAIL idle_access read got %h want %h", o.rd, keep); end
  endtask

  task automatic test_errors();
    obs_t o;
    logic [31:0] d = $urandom;
    xfer(1'b1, 1'b1, 8'h20, d, 4'hF, 8'd1, o);
    vectors++; if (o.err !== 1'b1) begin miscompares++; $display("FAIL err_range slverr got %b want 1", o.err); end
    vectors++; if (o.wr_n !== 0) begin miscompares++; $display("FAIL err_range wren_cycles got %0d want 0", o.wr_n); end
    vectors++; if (o.lat !== 2) begin miscompares++; $display("FAIL err_range lat got %0d want 2", o.lat); end
    vectors++; if (mem32[8'h20] !== ref32[8'h20]) begin miscompares++; $display("FAIL err_range mem got %h want %h", mem32[8'h20], ref32[8'h20]); end
    xfer(1'b1, 1'b1, 8'h10, d, 4'hF, 8'd0, o);
    vectors++; if (o.err !== 1'b1 || o.wr_n !== 0) begin miscompares++; $display("FAIL err_depth slverr/wren got %b/%0d want 1/0", o.err, o.wr_n); end
    xfer(1'b1, 1'b1, 8'h0F, d, 4'hF, 8'd0, o);
    ref32[8'h0F] = d;
    vectors++; if (o.err !== 1'b0 || o.wr_n !== 1) begin miscompares++; $display("FAIL last_word slverr/wren got %b/%0d want 0/1", o.err, o.wr_n); end
    xfer(1'b1, 1'b0, 8'h03, 32'h0, 4'h1, 8'd0, o);
    vectors++; if (o.err !== 1'b1) begin miscompares++; $display("FAIL err_strb slverr got %b want 1", o.err); end
    vectors++; if (o.rd !== 32'h0) begin miscompares++; $display("FAIL err_strb rdata got %h want 0", o.rd); end
  endtask

  task automatic test_abort();
    obs_t o;
    int   seen = 0;
    logic [7:0] d = ref8[8'h40] ^ 8'hFF;
    sel8 = 1'b1; enable = 1'b0; write = 1'b1; addr = 8'h40;
    wdata = {24'h0, d}; strb = 4'h1; wait_cycles = 8'd5;
    @(posedge clk); #1 enable = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ready8 || mem_wren8) seen++;
      @(posedge clk); #1;
    end
    sel8 = 1'b0; enable = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ready8 || mem_wren8) seen++;
      @(posedge clk); #1;
    end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL abort activity got %0d want 0", seen); end
    vectors++; if (mem8[8'h40] !== ref8[8'h40]) begin miscompares++; $display("FAIL abort mem got %h want %h", mem8[8'h40], ref8[8'h40]); end
    xfer(1'b0, 1'b1, 8'h40, {24'h0, d}, 4'h1, 8'd1, o);
    ref8[8'h40] = d;
    vectors++; if (o.lat !== 2 || o.wr_n !== 1) begin miscompares++; $display("FAIL post_abort lat/wren got %0d/%0d want 2/1", o.lat, o.wr_n); end
    vectors++; if (mem8[8'h40] !== d) begin miscompares++; $display("FAIL post_abort mem got %h want %h", mem8[8'h40], d); end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    int   seen = 0;
    logic [7:0] d = ref8[8'h30] ^ 8'hFF;
    sel8 = 1'b1; enable = 1'b0; write = 1'b1; addr = 8'h30;
    wdata = {24'h0, d}; strb = 4'h1; wait_cycles = 8'd10;
    @(posedge clk); #1 enable = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (ready8 || mem_wren8) seen++;
      @(posedge clk); #1;
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({ready8, slverr8, mem_wren8, mem_rden8, rdata8} !== 12'h0) begin
      miscompares++;
      $display("FAIL reset_mid_wait outputs got %h want 0", {ready8, slverr8, mem_wren8, mem_rden8, rdata8});
    end
    // Bus stays in access phase: an IDLE slave must ignore it.
    repeat (12) begin
      @(negedge clk);
      if (ready8 || mem_wren8) seen++;
      @(posedge clk); #1;
    end
    clear_bus();
    @(posedge clk); #1;
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL reset_mid_wait activity got %0d want 0", seen); end
    vectors++; if (mem8[8'h30] !== ref8[8'h30]) begin miscompares++; $display("FAIL reset_mid_wait mem got %h want %h", mem8[8'h30], ref8[8'h30]); end
    xfer(1'b0, 1'b0, 8'h30, 32'h0, 4'h0, 8'd2, o);
    vectors++; if (o.lat !== 3 || o.rd !== {24'h0, ref8[8'h30]}) begin
      miscompares++; $display("FAIL post_reset lat/rdata got %0d/%h want 3/%h", o.lat, o.rd, ref8[8'h30]);
    end
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    bit          wr;
    logic [7:0]  a, n;
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < 36; i++) begin
      wr = 1'($urandom_range(0, 1));
      a  = 8'($urandom_range(0, 19));
      d  = $urandom;
      case ($urandom_range(0, 2))
        0:       n = 8'd0;
        1:       n = 8'd1;
        default: n = 8'd255;
      endcase
      if (wr)                              s = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 5) == 0)  s = 4'($urandom_range(1, 15));
      else                                 s = 4'h0;
      e = predict(1'b1, wr, a, s, n);
      xfer(1'b1, wr, a, d, s, n, o);
      vectors++; if (o.lat !== e.lat) begin miscompares++; $display("FAIL b2b[%0d] lat got %0d want %0d", i, o.lat, e.lat); end
      vectors++; if (o.err !== e.err) begin miscompares++; $display("FAIL b2b[%0d] slverr got %b want %b", i, o.err, e.err); end
      vectors++; if (o.wr_n !== e.wr_n) begin miscompares++; $display("FAIL b2b[%0d] wren_cycles got %0d want %0d", i, o.wr_n, e.wr_n); end
      vectors++; if (o.rd_n !== e.rd_n) begin miscompares++; $display("FAIL b2b[%0d] rden_cycles got %0d want %0d", i, o.rd_n, e.rd_n); end
      if (!wr) begin
        vectors++; if (o.rd !== e.rd) begin miscompares++; $display("FAIL b2b[%0d] rdata got %h want %h", i, o.rd, e.rd); end
      end
      if (wr && !e.err)
        for (int k = 0; k < 4; k++)
          if (s[k]) ref32[a][8*k +: 8] = d[8*k +: 8];
    end
    for (int i = 0; i < 20; i++) begin
      vectors++;
      if (mem32[i] !== ref32[i]) begin
        miscompares++; $display("FAIL b2b_mem[%0d] got %h want %h", i, mem32[i], ref32[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ref8[i]  = 8'($urandom);
      mem8[i]  = ref8[i];
      ref32[i] = $urandom;
      mem32[i] = ref32[i];
    end
    test_reset();
    test_write();
    test_read();
    test_idle_access();
    test_errors();
    test_abort();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
